// File: rtl/sm_debug_ctrl_pkg.sv
// sm_debug_ctrl shared types
// Command opcodes, FSM state encodings and a state helper.
package sm_debug_ctrl_pkg;

  typedef enum logic [2:0] {
    DBG_NOP   = 3'd0,
    DBG_HALT  = 3'd1,
    DBG_RUN   = 3'd2,
    DBG_STEP  = 3'd3,
    DBG_SETBP = 3'd4,
    DBG_CLRBP = 3'd5,
    DBG_READ  = 3'd6,
    DBG_RSVD  = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    DBG_S_HALTED   = 3'd0,
    DBG_S_RUNNING  = 3'd1,
    DBG_S_STEPPING = 3'd2,
    DBG_S_READ     = 3'd3,
    DBG_S_RESP     = 3'd4
  } dbg_state_e;

  // States in which the CPU may be clocked
  function automatic logic isActive(dbg_state_e s);
    return (s == DBG_S_RUNNING) || (s == DBG_S_STEPPING);
  endfunction

endpackage

// File: rtl/sm_debug_ctrl_step_counter.sv
// sm_debug_ctrl step counter
// Loadable down-counter with zero and last-step flags.
module sm_debug_ctrl_step_counter #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] loadVal,
  input  logic              dec,
  output logic              zero,
  output logic              last
);

  logic [STEP_W-1:0] cnt;

  // Load wins over decrement; never decrements below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == STEP_W'(1));

endmodule

// File: rtl/sm_debug_ctrl.sv
// sm_debug_ctrl top
// Run/halt/step sequencer, PC breakpoint and debug register read.
module sm_debug_ctrl
  import sm_debug_ctrl_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b1,
  parameter int STEP_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        cpu_en,
  input  logic [31:0] cpu_pc,
  output logic [4:0]  dbg_regAddr,
  input  logic [31:0] dbg_regData,
  output logic        halted,
  output logic        bp_hit
);

  localparam dbg_state_e RESET_STATE =
    RUN_ON_RESET ? DBG_S_RUNNING : DBG_S_HALTED;

  dbg_state_e        state;
  dbg_state_e        stateNext;
  dbg_op_e           op;
  logic              accept;
  logic              bpEn;
  logic [31:0]       bpAddr;
  logic              bpMatch;
  logic              skip;
  logic              bpHit;
  logic              rspValid;
  logic [31:0]       rspData;
  logic [4:0]        readIdx;
  logic              stepLoad;
  logic [STEP_W-1:0] stepVal;
  logic              stepDec;
  logic              stepZero;
  logic              stepLast;
  logic              cpuEn;

  assign op        = dbg_op_e'(cmd_op);
  assign cmd_ready = (state == DBG_S_HALTED) || isActive(state);
  assign accept    = cmd_valid & cmd_ready;
  assign bpMatch   = isActive(state) & bpEn
                   & (cpu_pc == bpAddr) & ~skip;

  assign stepLoad = accept && (op == DBG_STEP);
  assign stepVal  = (cmd_arg[STEP_W-1:0] == '0)
                  ? STEP_W'(1) : cmd_arg[STEP_W-1:0];
  assign stepDec  = cpuEn && (state == DBG_S_STEPPING);

  sm_debug_ctrl_step_counter #(
    .STEP_W (STEP_W)
  ) uStep (
    .clk     (clk),
    .rst     (rst),
    .load    (stepLoad),
    .loadVal (stepVal),
    .dec     (stepDec),
    .zero    (stepZero),
    .last    (stepLast)
  );

  // CPU clock-enable: a breakpoint or a READ accept blocks retirement
  always_comb begin
    cpuEn = 1'b0;
    unique case (state)
      DBG_S_RUNNING:  cpuEn = 1'b1;
      DBG_S_STEPPING: cpuEn = ~stepZero;
      default:        cpuEn = 1'b0;
    endcase
    if (bpMatch) cpuEn = 1'b0;
    if (accept && (op == DBG_READ)) cpuEn = 1'b0;
  end

  // Next state: own transitions first, accepted commands override
  always_comb begin
    stateNext = state;
    unique case (state)
      DBG_S_RUNNING:
        if (bpMatch) stateNext = DBG_S_HALTED;
      DBG_S_STEPPING:
        if (bpMatch || stepZero || (cpuEn && stepLast))
          stateNext = DBG_S_HALTED;
      DBG_S_READ:
        stateNext = DBG_S_RESP;
      DBG_S_RESP:
        if (rsp_ready) stateNext = DBG_S_HALTED;
      default: ;
    endcase
    if (accept) begin
      unique case (op)
        DBG_HALT: stateNext = DBG_S_HALTED;
        DBG_RUN:  stateNext = DBG_S_RUNNING;
        DBG_STEP: stateNext = DBG_S_STEPPING;
        DBG_READ: stateNext = DBG_S_READ;
        default:  ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= stateNext;
  end

  // Breakpoint address, enable, sticky hit and resume-skip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bpEn   <= 1'b0;
      bpAddr <= '0;
      bpHit  <= 1'b0;
      skip   <= 1'b0;
    end else begin
      if (accept && (op == DBG_SETBP)) begin
        bpAddr <= cmd_arg;
        bpEn   <= 1'b1;
      end
      if (accept && (op == DBG_CLRBP)) bpEn <= 1'b0;
      if (accept && ((op == DBG_RUN) || (op == DBG_STEP)
                  || (op == DBG_CLRBP)))
        bpHit <= 1'b0;
      if (bpMatch) bpHit <= 1'b1;
      if (accept && ((op == DBG_RUN) || (op == DBG_STEP)))
        skip <= 1'b1;
      else if (cpuEn)
        skip <= 1'b0;
    end
  end

  // Register read: latch index, capture data in READ, hold in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      readIdx  <= '0;
      rspData  <= '0;
      rspValid <= 1'b0;
    end else begin
      if (accept && (op == DBG_READ)) readIdx <= cmd_arg[4:0];
      if (state == DBG_S_READ) begin
        rspData  <= dbg_regData;
        rspValid <= 1'b1;
      end else if ((state == DBG_S_RESP) && rsp_ready) begin
        rspValid <= 1'b0;
      end
    end
  end

  assign cpu_en      = cpuEn;
  assign bp_hit      = bpHit;
  assign rsp_valid   = rspValid;
  assign rsp_data    = rspData;
  assign dbg_regAddr = (state == DBG_S_READ) ? readIdx : 5'd0;
  assign halted      = (state == DBG_S_HALTED) || (state == DBG_S_READ)
                    || (state == DBG_S_RESP);

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// sm_debug_ctrl bench
// Directed run/step/breakpoint/read sequence against a tiny CPU stub.
module tb_sm_debug_ctrl;
  import sm_debug_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        cpu_en;
  logic [31:0] cpu_pc;
  logic [4:0]  dbg_regAddr;
  logic [31:0] dbg_regData;
  logic        halted;
  logic        bp_hit;

  logic        pcLoad;
  logic [31:0] pcLoadVal;
  logic [31:0] regs [32];
  int          retired = 0;
  int          nAssert = 0;
  int          nFail = 0;
  int          r0;
  logic [31:0] p;

  always #5 clk = ~clk;

  sm_debug_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .cpu_en      (cpu_en),
    .cpu_pc      (cpu_pc),
    .dbg_regAddr (dbg_regAddr),
    .dbg_regData (dbg_regData),
    .halted      (halted),
    .bp_hit      (bp_hit)
  );

  // CPU stub: PC advances by one word per enabled cycle
  always @(posedge clk) begin
    if (pcLoad) cpu_pc <= pcLoadVal;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd1;
    if (cpu_en) retired <= retired + 1;
  end

  always_comb begin
    dbg_regData = regs[dbg_regAddr];
    if (dbg_regAddr == 5'd0) dbg_regData = cpu_pc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = '0;
  endtask

  task automatic loadPc(input logic [31:0] v);
    pcLoad    = 1'b1;
    pcLoadVal = v;
    tick();
    pcLoad    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[8]   = 32'h0000_1234;
    regs[1]   = 32'hA5A5_0001;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = '0;
    rsp_ready = 1'b0;
    pcLoad    = 1'b1;
    pcLoadVal = '0;
    tick();
    tick();
    rst    = 1'b0;
    pcLoad = 1'b0;
    chk("run_on_reset_en", 32'(cpu_en), 1);
    tick();
    tick();
    tick();

    // Reset pulse while running
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cpu_en", 32'(cpu_en), 1);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_regaddr", 32'(dbg_regAddr), 0);

    // HALT then STEP 3 from 0x10
    send(DBG_HALT, 0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_cpu_en", 32'(cpu_en), 0);
    loadPc(32'h10);
    r0 = retired;
    send(DBG_STEP, 3);
    for (int i = 0; i < 5; i++) begin
      chk("step3_en", 32'(cpu_en), (i < 3) ? 1 : 0);
      tick();
    end
    chk("step3_retired", 32'(retired - r0), 3);
    chk("step3_pc", cpu_pc, 32'h13);
    chk("step3_halted", 32'(halted), 1);
    r0 = retired;
    send(DBG_STEP, 0);
    tick();
    tick();
    chk("step0_retired", 32'(retired - r0), 1);
    chk("step0_pc", cpu_pc, 32'h14);
    chk("step0_halted", 32'(halted), 1);

    // Breakpoint at 5, run from 0, then resume past it
    send(DBG_SETBP, 32'h5);
    loadPc(32'h0);
    send(DBG_RUN, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_pc", cpu_pc, 32'h5);
    chk("bp_cpu_en", 32'(cpu_en), 0);
    chk("bp_not_yet_halted", 32'(halted), 0);
    tick();
    chk("bp_halted", 32'(halted), 1);
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_pc_held", cpu_pc, 32'h5);
    send(DBG_RUN, 0);
    chk("resume_en", 32'(cpu_en), 1);
    chk("resume_bp_hit_clr", 32'(bp_hit), 0);
    tick();
    chk("resume_pc6", cpu_pc, 32'h6);
    tick();
    tick();
    chk("resume_pc8", cpu_pc, 32'h8);
    chk("resume_running", 32'(halted), 0);

    // READ_REG 8 while running
    cmd_valid = 1'b1;
    cmd_op    = DBG_READ;
    cmd_arg   = 32'd8;
    #1;
    chk("read_accept_en", 32'(cpu_en), 0);
    p = cpu_pc;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = '0;
    chk("read_halted", 32'(halted), 1);
    chk("read_regaddr", 32'(dbg_regAddr), 8);
    chk("read_rsp_early", 32'(rsp_valid), 0);
    chk("read_cmd_ready", 32'(cmd_ready), 0);
    tick();
    chk("resp_valid", 32'(rsp_valid), 1);
    chk("resp_data", rsp_data, 32'h1234);
    chk("resp_regaddr", 32'(dbg_regAddr), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("resp_hold_valid", 32'(rsp_valid), 1);
      chk("resp_hold_data", rsp_data, 32'h1234);
      chk("resp_hold_ready", 32'(cmd_ready), 0);
    end
    chk("resp_pc_frozen", cpu_pc, p);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("resp_done_valid", 32'(rsp_valid), 0);
    chk("resp_done_halted", 32'(halted), 1);
    chk("resp_done_ready", 32'(cmd_ready), 1);
    p = cpu_pc;
    send(DBG_READ, 0);
    tick();
    chk("read_pc_valid", 32'(rsp_valid), 1);
    chk("read_pc_data", rsp_data, p);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // STEP 4 with breakpoint on the second stepped PC
    loadPc(32'h20);
    send(DBG_SETBP, 32'h21);
    r0 = retired;
    send(DBG_STEP, 4);
    chk("stepbp_en0", 32'(cpu_en), 1);
    tick();
    chk("stepbp_pc", cpu_pc, 32'h21);
    chk("stepbp_en1", 32'(cpu_en), 0);
    tick();
    chk("stepbp_halted", 32'(halted), 1);
    chk("stepbp_hit", 32'(bp_hit), 1);
    chk("stepbp_pc_held", cpu_pc, 32'h21);
    chk("stepbp_retired", 32'(retired - r0), 1);
    chk("stepbp_cnt", 32'(dut.uStep.cnt), 3);
    send(DBG_CLRBP, 0);
    chk("clrbp_hit", 32'(bp_hit), 0);

    // Reset while a response is pending
    send(DBG_SETBP, 32'h100);
    send(DBG_READ, 1);
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    chk("pre_rst_data", rsp_data, 32'hA5A5_0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("resp_rst_valid", 32'(rsp_valid), 0);
    chk("resp_rst_data", rsp_data, 0);
    chk("resp_rst_halted", 32'(halted), 0);
    chk("resp_rst_en", 32'(cpu_en), 1);
    chk("resp_rst_bpen", 32'(dut.bpEn), 0);
    chk("resp_rst_ready", 32'(cmd_ready), 1);
    tick();
    tick();
    chk("resp_rst_running", 32'(halted), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
